hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-index width.
REQ-002 Parameter: FLUSH_CYCLES, default 1, extra flush cycles after a mispredict (range 1..7).
REQ-003 Parameter: MEM_TIMEOUT, default 255, MEM_WAIT cycle count that raises mem_timeout (range 1..255).
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 id_rs1, id_rs2  in  REG_ADDR_W each  source registers of the instruction in decode.
REQ-007 ex_rd  in  REG_ADDR_W  destination register of the instruction in execute.
REQ-008 ex_mem_read  in  1  instruction in execute is a load.
REQ-009 branch_mispredict  in  1  EX-stage redirect, one-cycle pulse.
REQ-010 mem_busy  in  1  data memory not ready; level signal.
REQ-011 stall_if, stall_id, stall_ex  out  1 each  hold PC, IF/ID, ID/EX respectively.
REQ-012 flush_id, flush_ex  out  1 each  replace IF/ID, ID/EX contents with NOP.
REQ-013 mem_timeout  out  1  sticky error flag.
REQ-014 state_o  out  2  current FSM state (RUN=0, FLUSH=1, MEM_WAIT=2).

Function
REQ-015 State register, wait counter (8 bit), flush counter (3 bit), pending_flush flag: all updated on posedge clk only.
REQ-016 Stall/flush outputs: combinational from current state and inputs; take effect in the same cycle.
REQ-017 load_use = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2).
REQ-018 RUN, priority 1, mem_busy=1: stall_if=stall_id=stall_ex=1; flushes 0; next MEM_WAIT, wait counter=1; if branch_mispredict also 1, set pending_flush.
REQ-019 RUN, priority 2, branch_mispredict=1: flush_id=flush_ex=1; stalls 0; next FLUSH, flush counter=FLUSH_CYCLES.
REQ-020 RUN, priority 3, load_use=1: stall_if=stall_id=1, flush_ex=1 (one bubble); stay RUN.
REQ-021 RUN, no event: all stall/flush outputs 0.
REQ-022 FLUSH: flush_id=flush_ex=1 every cycle; counter decrements; exit to RUN when counter reaches 1 this cycle.
REQ-023 FLUSH: load_use ignored; a new branch_mispredict reloads counter to FLUSH_CYCLES.
REQ-024 FLUSH with mem_busy=1: move to MEM_WAIT; remaining flush recorded via pending_flush.
REQ-025 MEM_WAIT: stall_if=stall_id=stall_ex=1, flushes 0; wait counter increments, saturating at 255.
REQ-026 MEM_WAIT: mem_timeout set when counter equals MEM_TIMEOUT while mem_busy=1; cleared only by reset.
REQ-027 MEM_WAIT, mem_busy=0: stalls 0 this cycle; next FLUSH (counter=FLUSH_CYCLES) if pending_flush, else RUN; pending_flush cleared.
REQ-028 MEM_WAIT: branch_mispredict=1 sets pending_flush.

Reset
REQ-029 rst=1 on posedge: state=RUN, counters=0, pending_flush=0, mem_timeout=0.
REQ-030 While rst=1: all stall/flush outputs forced 0.
REQ-031 Reset mid-MEM_WAIT or mid-FLUSH abandons the operation; no pending event survives.

Configuration
REQ-032 Macro HAZARD_PERF_EN defined: adds outputs stall_cycles (32 bit) and flush_events (16 bit), both saturating, cleared by rst.
REQ-033 stall_cycles increments each cycle stall_if=1; flush_events increments on each RUN->FLUSH or MEM_WAIT->FLUSH transition.
REQ-034 HAZARD_PERF_EN undefined: those ports and counters are absent; all other behaviour identical.

Verification
REQ-035 ex_mem_read=1, ex_rd=5, id_rs2=5, other inputs 0 -> one cycle of stall_if=stall_id=flush_ex=1; state_o stays 0.
REQ-036 ex_rd=0, ex_mem_read=1, id_rs1=0 -> no stall.
REQ-037 FLUSH_CYCLES=2, mispredict pulse -> flush_id=flush_ex=1 for 3 consecutive cycles; state_o 1,1 then 0.
REQ-038 mem_busy and mispredict asserted together, mem_busy held 4 cycles -> 4 stall cycles with no flush, then FLUSH entered.
REQ-039 MEM_TIMEOUT=10, mem_busy held 20 cycles -> mem_timeout rises after the 10th MEM_WAIT cycle and stays high until rst.
REQ-040 rst asserted in the 3rd MEM_WAIT cycle -> next cycle state_o=0, all outputs 0, pending_flush lost.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller (load-use bubble, mispredict
// flush, data-memory wait) for a classic five-stage pipeline.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   id_rs1, id_rs2        source registers of the decode-stage instruction
//   ex_rd                 destination register of the execute-stage instruction
//   ex_mem_read           execute-stage instruction is a load
//   branch_mispredict     one-cycle EX redirect pulse
//   mem_busy              data memory not ready (level)
//   stall_if/id/ex        hold PC, IF/ID, ID/EX
//   flush_id/ex           squash IF/ID, ID/EX to NOP
//   mem_timeout           sticky: MEM_WAIT lasted MEM_TIMEOUT cycles
//   state_o               RUN=0, FLUSH=1, MEM_WAIT=2
//
// Optional build macro HAZARD_PERF_EN adds saturating performance counters
// stall_cycles (cycles with stall_if=1) and flush_events (entries into FLUSH).
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_mispredict,
  input  logic                  mem_busy,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_events,
`endif
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_cnt_nx;
  logic [2:0] flush_cnt, flush_cnt_nx;
  logic       pending_flush, pending_flush_nx;
  logic       timeout_hit;
  logic       load_use;
  logic       s_if, s_id, s_ex, f_id, f_ex;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      wait_cnt      <= '0;
      flush_cnt     <= '0;
      pending_flush <= 1'b0;
      mem_timeout   <= 1'b0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= wait_cnt_nx;
      flush_cnt     <= flush_cnt_nx;
      pending_flush <= pending_flush_nx;
      if (timeout_hit) mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nx         = state;
    wait_cnt_nx      = wait_cnt;
    flush_cnt_nx     = flush_cnt;
    pending_flush_nx = pending_flush;
    timeout_hit      = 1'b0;
    s_if = 1'b0; s_id = 1'b0; s_ex = 1'b0;
    f_id = 1'b0; f_ex = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1;
          state_nx    = MEM_WAIT;
          wait_cnt_nx = 8'd1;
          if (branch_mispredict) pending_flush_nx = 1'b1;
        end else if (branch_mispredict) begin
          f_id = 1'b1; f_ex = 1'b1;
          state_nx     = FLUSH;
          flush_cnt_nx = FLUSH_LOAD;
        end else if (load_use) begin
          s_if = 1'b1; s_id = 1'b1; f_ex = 1'b1;
        end
      end
      FLUSH: begin
        f_id = 1'b1; f_ex = 1'b1;
        if (mem_busy) begin
          // Flush work is owed only if cycles remain after this one, or a
          // fresh redirect arrived in this same cycle.
          state_nx         = MEM_WAIT;
          wait_cnt_nx      = 8'd1;
          pending_flush_nx = branch_mispredict || (flush_cnt > 3'd1);
        end else if (branch_mispredict) begin
          flush_cnt_nx = FLUSH_LOAD;
        end else begin
          flush_cnt_nx = (flush_cnt != '0) ? flush_cnt - 3'd1 : '0;
          if (flush_cnt <= 3'd1) state_nx = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          s_if = 1'b1; s_id = 1'b1; s_ex = 1'b1;
          timeout_hit = (wait_cnt == TIMEOUT_CNT);
          if (wait_cnt != 8'hFF) wait_cnt_nx = wait_cnt + 8'd1;
          if (branch_mispredict) pending_flush_nx = 1'b1;
        end else begin
          pending_flush_nx = 1'b0;
          if (pending_flush || branch_mispredict) begin
            state_nx     = FLUSH;
            flush_cnt_nx = FLUSH_LOAD;
          end else begin
            state_nx = RUN;
          end
        end
      end
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    stall_if = s_if & ~rst;
    stall_id = s_id & ~rst;
    stall_ex = s_ex & ~rst;
    flush_id = f_id & ~rst;
    flush_ex = f_ex & ~rst;
  end

  assign state_o = state;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_if && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if ((state_nx == FLUSH) && (state != FLUSH) && (flush_events != '1))
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int FC = 2;
  localparam int MT = 10;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, branch_mispredict, mem_busy;
  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, mem_timeout;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
`endif

  hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_mispredict(branch_mispredict),
    .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .mem_timeout(mem_timeout),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected vector: {stall_if, stall_id, stall_ex, flush_id, flush_ex, mem_timeout, state[1:0]}
  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pipeline situation described as "phase" plus how many
  // flush cycles are still owed, how long memory has been waited on, etc.
  int phase       = 0;   // 0 running, 1 flushing, 2 waiting on memory
  int flush_left  = 0;
  int waited      = 0;
  bit owed_flush  = 0;
  bit timed_out   = 0;

  task automatic drive_cycle(input bit r, input int rs1, input int rs2, input int rd,
                             input bit mr, input bit bm, input bit mb);
    bit hit;
    bit [4:0] o;   // {stall_if, stall_id, stall_ex, flush_id, flush_ex}
    exp_t e;
    @(negedge clk);
    rst = r; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); ex_rd = 5'(rd);
    ex_mem_read = mr; branch_mispredict = bm; mem_busy = mb;
    #1;
    hit = mr && (rd != 0) && (rd == rs1 || rd == rs2);
    o = 5'b00000;
    e.cyc = cyc;
    e.v[2] = timed_out;
    e.v[1:0] = 2'(phase);
    if (r) begin
      phase = 0; flush_left = 0; waited = 0; owed_flush = 0; timed_out = 0;
    end else if (phase == 0) begin
      if (mb) begin
        o = 5'b11100; phase = 2; waited = 1; owed_flush = owed_flush | bm;
      end else if (bm) begin
        o = 5'b00011; phase = 1; flush_left = FC;
      end else if (hit) begin
        o = 5'b11001;
      end
    end else if (phase == 1) begin
      o = 5'b00011;
      if (mb) begin
        phase = 2; waited = 1; owed_flush = bm || (flush_left > 1);
      end else if (bm) begin
        flush_left = FC;
      end else begin
        flush_left = flush_left - 1;
        if (flush_left <= 0) begin flush_left = 0; phase = 0; end
      end
    end else begin
      if (mb) begin
        o = 5'b11100;
        if (waited == MT) timed_out = 1;
        waited = (waited < 255) ? waited + 1 : 255;
        owed_flush = owed_flush | bm;
      end else begin
        if (owed_flush || bm) begin phase = 1; flush_left = FC; end
        else phase = 0;
        owed_flush = 0;
      end
    end
    e.v[7:3] = o;
    sb.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a response; compare with the head of the queue.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {stall_if, stall_id, stall_ex, flush_id, flush_ex, mem_timeout, state_o};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL cyc%0d outputs{sif,sid,sex,fid,fex,tmo,st} got=%b want=%b",
                   e.cyc, act, e.v);
        end
      end
    end
  end

  initial begin
    int busy_left;
    rst = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 1'b0; branch_mispredict = 1'b0; mem_busy = 1'b0;
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on rs2, then x0 never hazards
    drive_cycle(0, 1, 5, 5, 1, 0, 0);
    idle(1);
    drive_cycle(0, 0, 3, 0, 1, 0, 0);
    drive_cycle(0, 7, 0, 7, 1, 0, 0);
    idle(1);
    // mispredict pulse
    drive_cycle(0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // busy + mispredict together, busy held 4 cycles
    drive_cycle(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0, 1);
    idle(5);
    // long memory wait to trip the timeout, which must persist
    for (int i = 0; i < 20; i++) drive_cycle(0, 0, 0, 0, 0, 0, 1);
    idle(4);
    drive_cycle(0, 2, 2, 2, 1, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // reset during the 3rd MEM_WAIT cycle drops the owed flush
    drive_cycle(0, 0, 0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 1);
    drive_cycle(1, 0, 0, 0, 0, 0, 1);
    idle(3);
    // memory stall arriving mid-flush, and a mispredict reloading the flush
    drive_cycle(0, 0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 0, 1);
    idle(4);
    drive_cycle(0, 0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // randomized traffic
    busy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit mb;
      if (busy_left == 0 && $urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 14);
      mb = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      drive_cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, mb);
    end
    @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: unchecked=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
